// File: rtl/text_scroll_engine.sv
`default_nettype none
// ============================================================================
// Module   : text_scroll_engine
// Brief    : Scrolls a row window of the 80x25 text page up/down and fills
//            the vacated rows, driving the shared video-RAM write port.
// Revision : 1.0 - initial release
// ============================================================================
module text_scroll_engine #(
    parameter logic [16:0] BASE = 17'h0F000,
    parameter int          COLS = 80,
    parameter int          ROWS = 25
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_dir,
    input  logic [4:0]  i_top,
    input  logic [4:0]  i_bottom,
    input  logic [4:0]  i_lines,
    input  logic [7:0]  i_fill_char,
    input  logic [7:0]  i_fill_attr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [16:0] o_address,
    output logic [7:0]  o_wdata,
    output logic        o_rd,
    output logic        o_we,
    input  logic [7:0]  i_rdata,
    input  logic        i_stall
);
    localparam int              c_ROW_BYTES = 2 * COLS;
    localparam int              c_BW        = $clog2(c_ROW_BYTES);
    localparam logic [c_BW-1:0] c_LAST      = c_BW'(c_ROW_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_COPY_RD, S_COPY_CAP, S_COPY_WR, S_FILL, S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic            r_dir, r_err;
    logic [4:0]      r_top, r_bot, r_lines, r_n, r_cnt, r_row;
    logic [c_BW-1:0] r_byte;
    logic [7:0]      r_data, r_fc, r_fa;

    logic [5:0]  w_h, w_n6, w_copy;
    logic        w_invalid, w_last;
    logic [4:0]  w_src, w_arow, w_fill_row;
    logic [16:0] w_addr;

    assign w_invalid  = (r_top > r_bot) || ({1'b0, r_bot} >= 6'(ROWS));
    assign w_h        = {1'b0, r_bot} - {1'b0, r_top} + 6'd1;
    assign w_n6       = ((r_lines == 5'd0) || ({1'b0, r_lines} > w_h)) ? w_h : {1'b0, r_lines};
    assign w_copy     = w_h - w_n6;
    assign w_last     = (r_byte == c_LAST);
    assign w_src      = r_dir ? (r_row - r_n) : (r_row + r_n);
    assign w_arow     = (r_state == S_COPY_RD) ? w_src : r_row;
    assign w_fill_row = r_dir ? r_top : (r_bot - r_n + 5'd1);
    assign w_addr     = BASE + 17'(w_arow) * 17'(c_ROW_BYTES) + 17'(r_byte);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_next = S_CHECK;
            S_CHECK: begin
                if (w_invalid)          w_next = S_DONE;
                else if (w_copy != 6'd0) w_next = S_COPY_RD;
                else                    w_next = S_FILL;
            end
            S_COPY_RD:  if (!i_stall) w_next = S_COPY_CAP;
            S_COPY_CAP: w_next = S_COPY_WR;
            S_COPY_WR:  if (!i_stall) w_next = (w_last && r_cnt == 5'd1) ? S_FILL : S_COPY_RD;
            S_FILL:     if (!i_stall && w_last && r_cnt == 5'd1) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dir <= 1'b0; r_err <= 1'b0;
            r_top <= '0; r_bot <= '0; r_lines <= '0; r_n <= '0;
            r_cnt <= '0; r_row <= '0; r_byte <= '0;
            r_data <= '0; r_fc <= '0; r_fa <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_dir <= i_dir; r_top <= i_top; r_bot <= i_bottom;
                    r_lines <= i_lines; r_fc <= i_fill_char; r_fa <= i_fill_attr;
                end
                S_CHECK: begin
                    r_err  <= w_invalid;
                    r_n    <= w_n6[4:0];
                    r_byte <= '0;
                    if (w_copy != 6'd0) begin
                        r_cnt <= w_copy[4:0];
                        r_row <= r_dir ? r_bot : r_top;
                    end else begin
                        r_cnt <= w_n6[4:0];
                        r_row <= r_dir ? r_top : (r_bot - w_n6[4:0] + 5'd1);
                    end
                end
                S_COPY_CAP: r_data <= i_rdata;
                S_COPY_WR: if (!i_stall) begin
                    if (w_last) begin
                        r_byte <= '0;
                        // Last copied row hands over to the fill pass.
                        if (r_cnt == 5'd1) begin
                            r_row <= w_fill_row;
                            r_cnt <= r_n;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                            r_row <= r_dir ? (r_row - 5'd1) : (r_row + 5'd1);
                        end
                    end else begin
                        r_byte <= r_byte + c_BW'(1);
                    end
                end
                S_FILL: if (!i_stall) begin
                    if (w_last) begin
                        r_byte <= '0;
                        r_cnt  <= r_cnt - 5'd1;
                        r_row  <= r_row + 5'd1;
                    end else begin
                        r_byte <= r_byte + c_BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done    = (r_state == S_DONE);
    assign o_error   = (r_state == S_DONE) && r_err;
    assign o_rd      = (r_state == S_COPY_RD);
    assign o_we      = (r_state == S_COPY_WR) || (r_state == S_FILL);
    assign o_address = (o_rd || o_we) ? w_addr : 17'd0;
    assign o_wdata   = (r_state == S_COPY_WR) ? r_data :
                       (r_state == S_FILL)    ? (r_byte[0] ? r_fa : r_fc) : 8'd0;
endmodule
`default_nettype wire

// File: tb/tb_text_scroll_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_scroll_engine
// Brief    : Scoreboarded bench with a video-RAM model for text_scroll_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_scroll_engine;
    localparam int          RB   = 160;
    localparam int          NB   = 4000;
    localparam logic [16:0] BASE = 17'h0F000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0, stall = 1'b0;
    logic [4:0]  top = '0, bottom = '0, lines = '0;
    logic [7:0]  fc = '0, fa = '0, rdata = '0;
    logic        busy, done, error, rd, we;
    logic [16:0] address;
    logic [7:0]  wdata;

    text_scroll_engine #(.BASE(BASE), .COLS(80), .ROWS(25)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_dir(dir),
        .i_top(top), .i_bottom(bottom), .i_lines(lines),
        .i_fill_char(fc), .i_fill_attr(fa),
        .o_busy(busy), .o_done(done), .o_error(error),
        .o_address(address), .o_wdata(wdata), .o_rd(rd), .o_we(we),
        .i_rdata(rdata), .i_stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct { int err; int cycles; int reads; int writes; } exp_t;
    exp_t sbq[$];

    logic [7:0] mem [NB];
    logic [7:0] orig [NB];
    logic [7:0] exp_m [NB];
    int tests = 0, fails = 0, done_cnt = 0;
    int cyc = 0, rcnt = 0, wcnt = 0, oob = 0, stall_viol = 0;
    int win_top = 0, win_bot = 24;
    bit stall_en = 1'b0;

    function automatic void check(string nm, int act, int ex);
        tests++;
        if (act != ex) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, ex);
        end
    endfunction

    // Video RAM: read data appears the cycle after an accepted read.
    always @(posedge clk) begin
        int a;
        a = int'(address) - int'(BASE);
        if (!stall && (a >= 0) && (a < NB)) begin
            if (rd) rdata <= mem[a];
            if (we) mem[a] <= wdata;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        stall = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: counts traffic, checks held requests, scores each done pulse.
    initial begin
        bit pend = 1'b0;
        logic [16:0] pa; logic [7:0] pw; logic prd, pwe;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; rcnt = 0; wcnt = 0; oob = 0; pend = 1'b0;
            end else begin
                int a, row;
                if (pend && (address !== pa || wdata !== pw || rd !== prd || we !== pwe))
                    stall_viol++;
                pend = (rd || we) && stall;
                pa = address; pw = wdata; prd = rd; pwe = we;
                if (busy || done) cyc++;
                if ((rd || we) && !stall) begin
                    a = int'(address) - int'(BASE);
                    row = a / RB;
                    if (a < 0 || a >= NB || row < win_top || row > win_bot) oob++;
                    if (rd) rcnt++;
                    if (we) wcnt++;
                end
                if (done) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("error_flag", int'(error), e.err);
                        check("busy_in_done", int'(busy), 0);
                        if (e.cycles != 0) check("cycles", cyc, e.cycles);
                        check("reads", rcnt, e.reads);
                        check("writes", wcnt, e.writes);
                        check("out_of_window", oob, 0);
                    end
                    cyc = 0; rcnt = 0; wcnt = 0; oob = 0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic model(input bit d, input int t, input int b, input int l,
                         input logic [7:0] c, input logic [7:0] at);
        int h, n;
        for (int i = 0; i < NB; i++) exp_m[i] = orig[i];
        if (t > b || b >= 25) return;
        h = b - t + 1;
        n = (l == 0 || l > h) ? h : l;
        for (int r = t; r <= b; r++) begin
            bit fill;
            int src;
            fill = d ? (r < t + n) : (r > b - n);
            src  = d ? r - n : r + n;
            for (int j = 0; j < RB; j++)
                exp_m[r*RB + j] = fill ? ((j % 2 == 0) ? c : at) : orig[src*RB + j];
        end
    endtask

    task automatic init_page();
        for (int i = 0; i < NB; i++) mem[i] = 8'((i * 7) ^ (i >> 5));
    endtask

    task automatic run(input string nm, input bit d, input int t, input int b, input int l,
                       input logic [7:0] c, input logic [7:0] at,
                       input int err, input int cycles, input int reads, input int writes,
                       input bit spam);
        exp_t e;
        int d0, mm;
        bit ok;
        @(posedge clk); #1;
        for (int i = 0; i < NB; i++) orig[i] = mem[i];
        model(d, t, b, l, c, at);
        e.err = err; e.cycles = cycles; e.reads = reads; e.writes = writes;
        sbq.push_back(e);
        win_top = t; win_bot = b;
        d0 = done_cnt;
        dir = d; top = 5'(t); bottom = 5'(b); lines = 5'(l); fc = c; fa = at; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dir = ~d; top = 5'd0; bottom = 5'd24; lines = 5'd3; fc = 8'hFF; fa = 8'hEE;
        ok = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            if (done_cnt != d0) begin ok = 1'b1; break; end
            if (spam && busy && (i % 997 == 500)) begin
                start = 1'b1; @(posedge clk); #1; start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            check({nm, "_timeout"}, 1, 0);
            void'(sbq.pop_front());
        end
        mm = 0;
        for (int i = 0; i < NB; i++) if (mem[i] !== exp_m[i]) mm++;
        check({nm, "_mem_bad_bytes"}, mm, 0);
    endtask

    initial begin
        bit seen;
        init_page();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_rd_we", int'({rd, we}), 0);
        check("rst_address", int'(address), 0);
        check("rst_wdata", int'(wdata), 0);
        rst = 1'b0;

        run("t1_up_full", 1'b0, 0, 24, 1, 8'h20, 8'h07, 0, 11682, 3840, 4000, 1'b0);
        run("t2_down", 1'b1, 5, 9, 2, 8'h2A, 8'h1F, 0, 1762, 480, 800, 1'b0);
        run("t3_lines0", 1'b0, 2, 3, 0, 8'h41, 8'h1E, 0, 322, 0, 320, 1'b0);
        run("t3_lines31", 1'b1, 2, 3, 31, 8'h42, 8'h2E, 0, 322, 0, 320, 1'b0);
        run("t4_top_gt_bot", 1'b0, 10, 4, 1, 8'h00, 8'h00, 1, 2, 0, 0, 1'b0);
        run("t4_bot_25", 1'b0, 20, 25, 1, 8'h00, 8'h00, 1, 2, 0, 0, 1'b0);

        init_page();
        stall_viol = 0;
        stall_en = 1'b1;
        run("t5_stall", 1'b0, 0, 24, 1, 8'h20, 8'h07, 0, 0, 3840, 4000, 1'b1);
        stall_en = 1'b0;
        check("t5_stall_hold", stall_viol, 0);

        // Abort a running command at its first copy write.
        @(posedge clk); #1;
        win_top = 0; win_bot = 24;
        dir = 1'b0; top = 5'd0; bottom = 5'd24; lines = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (we) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("t6_reach_copy_wr", int'(seen), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_rd", int'(rd), 0);
        check("t6_rst_we", int'(we), 0);
        check("t6_rst_busy", int'(busy), 0);
        rst = 1'b0;
        run("t6_after_rst", 1'b1, 5, 9, 2, 8'h2A, 8'h1F, 0, 1762, 480, 800, 1'b0);
        check("t6_sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
